// File: rtl/serial_sub16.sv
// serial_sub16 -- bit-serial 16-bit subtractor with valid/ready handshakes.
//
// Computes y = a - b - Bin (mod 2^16), Bo = borrow out (a < b + Bin unsigned)
// and ovf = signed two's-complement overflow. The subtraction is done
// BITS_PER_CYCLE bits at a time, LSB first, as a + ~b + ~borrow.
//
// Parameter:
//   BITS_PER_CYCLE  operand bits per CALC cycle; 1, 2, 4, 8 or 16.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid          in_ready   block can accept operands
//   a, b, Bin  minuend, subtrahend, borrow in
//   out_valid  result valid            out_ready  consumer accepts result
//   y, Bo, ovf difference, borrow out, signed overflow
// Configuration:
//   SERIAL_SUB16_OVF_EN  compiles in the signed-overflow logic; when left
//                        undefined the ovf port is tied to 0.
//
// Timing: operands are taken on the accepting edge, CALC then runs for
// 16/BITS_PER_CYCLE cycles, and the result registers are loaded on the first
// HOLD edge, so out_valid rises 16/BITS_PER_CYCLE+1 edges after acceptance.
module serial_sub16 #(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        Bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] y,
    output logic        Bo,
    output logic        ovf
);

    localparam int          NUM_SLICES = 16 / BITS_PER_CYCLE;
    localparam logic [4:0]  LAST_SLICE = 5'(NUM_SLICES - 1);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        ready_en_reg;   // low during reset and until the first edge after it
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [15:0] diff_reg;       // partial difference, filled from the top down
    logic        borrow_reg;
    logic [4:0]  cnt_reg;
    logic        done_reg;       // result registers loaded in this HOLD visit
    logic [15:0] y_reg;
    logic        bo_reg;
    logic        accept;

    logic [BITS_PER_CYCLE:0] slice_sum;
    logic [15:0]             diff_next;

    // One slice of a + ~b + ~borrow; the carry out is the inverted borrow.
    assign slice_sum = {1'b0, a_reg[BITS_PER_CYCLE-1:0]}
                     + {1'b0, ~b_reg[BITS_PER_CYCLE-1:0]}
                     + {{BITS_PER_CYCLE{1'b0}}, ~borrow_reg};

    // New slice enters at the top so after the last slice diff_reg is aligned.
    generate
        if (BITS_PER_CYCLE == 16) begin : g_full_width
            assign diff_next = slice_sum[15:0];
        end else begin : g_sliced
            assign diff_next = {slice_sum[BITS_PER_CYCLE-1:0],
                                diff_reg[15:BITS_PER_CYCLE]};
        end
    endgenerate

    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)                    state_next = CALC;
            CALC:    if (cnt_reg == LAST_SLICE)     state_next = HOLD;
            HOLD:    if (done_reg && out_ready)     state_next = IDLE;
            default:                                state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_reg == IDLE) && ready_en_reg;
        out_valid = (state_reg == HOLD) && done_reg;
        y         = y_reg;
        Bo        = bo_reg;
    end

`ifdef SERIAL_SUB16_OVF_EN
    logic a_msb_reg;
    logic b_msb_reg;
    logic ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (state_reg == IDLE && accept) begin
            a_msb_reg <= a[15];
            b_msb_reg <= b[15];
        end else if (state_reg == HOLD && !done_reg) begin
            // Overflow when operand signs differ and the result sign
            // disagrees with the minuend.
            ovf_reg <= (a_msb_reg != b_msb_reg) && (diff_reg[15] != a_msb_reg);
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            diff_reg     <= '0;
            borrow_reg   <= 1'b0;
            cnt_reg      <= '0;
            done_reg     <= 1'b0;
            y_reg        <= '0;
            bo_reg       <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        borrow_reg <= Bin;
                        cnt_reg    <= '0;
                        done_reg   <= 1'b0;
                    end
                end
                CALC: begin
                    a_reg      <= a_reg >> BITS_PER_CYCLE;
                    b_reg      <= b_reg >> BITS_PER_CYCLE;
                    diff_reg   <= diff_next;
                    borrow_reg <= ~slice_sum[BITS_PER_CYCLE];
                    cnt_reg    <= cnt_reg + 5'd1;
                end
                HOLD: begin
                    if (!done_reg) begin
                        y_reg    <= diff_reg;
                        bo_reg   <= borrow_reg;
                        done_reg <= 1'b1;
                    end else if (out_ready) begin
                        done_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub16.sv
// Self-checking bench for serial_sub16. One instance per legal
// BITS_PER_CYCLE (1, 2, 4, 8, 16) shares the same stimulus; every
// transaction pushes its expected result to a scoreboard queue and all
// instances are compared against the popped entry when their results appear.
module tb_serial_sub16;

    localparam int NI = 5;

    typedef struct packed {
        logic [15:0] y;
        logic        bo;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic        out_ready;

    logic        in_ready_w  [NI];
    logic        out_valid_w [NI];
    logic [15:0] y_w         [NI];
    logic        bo_w        [NI];
    logic        ovf_w       [NI];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            serial_sub16 #(.BITS_PER_CYCLE(1 << gi)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (in_ready_w[gi]),
                .a         (a),
                .b         (b),
                .Bin       (borrow_in),
                .out_valid (out_valid_w[gi]),
                .out_ready (out_ready),
                .y         (y_w[gi]),
                .Bo        (bo_w[gi]),
                .ovf       (ovf_w[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int idx,
                            input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%h exp=%h", tag, idx, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mbin);
        exp_t        r;
        logic [16:0] d;
        d     = {1'b0, ma} - {1'b0, mb} - 17'(mbin);
        r.y   = d[15:0];
        r.bo  = d[16];
`ifdef SERIAL_SUB16_OVF_EN
        r.ovf = (ma[15] != mb[15]) && (d[15] != ma[15]);
`else
        r.ovf = 1'b0;
`endif
        return r;
    endfunction

    function automatic bit all_ready();
        bit r = 1'b1;
        for (int i = 0; i < NI; i++) if (in_ready_w[i] !== 1'b1) r = 1'b0;
        return r;
    endfunction

    // Wait (bounded) until every instance is idle, then accept one operand set.
    task automatic launch(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tbin);
        int waited = 0;
        while (!all_ready() && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check_eq("ready_wait", 0, 32'(waited < 50), 32'd1);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        borrow_in = tbin;
        @(posedge clk); #1;
        // Scramble the operand bus: the DUT must already hold its copy.
        in_valid  = 1'b0;
        a         = 16'($urandom);
        b         = 16'($urandom);
        borrow_in = 1'($urandom);
    endtask

    // Full transaction: launch, measure latency, compare, optional stall
    // with out_ready low, then release.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tbin, input int stall);
        int   lat [NI];
        bit   all_v;
        exp_t e;
        sb.push_back(model(ta, tb_v, tbin));
        out_ready = 1'b0;
        launch(ta, tb_v, tbin);
        for (int i = 0; i < NI; i++) lat[i] = 0;
        for (int edge_n = 1; edge_n <= 40; edge_n++) begin
            @(posedge clk); #1;
            all_v = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (out_valid_w[i] === 1'b1 && lat[i] == 0) lat[i] = edge_n;
                if (lat[i] == 0) all_v = 1'b0;
            end
            if (all_v) break;
        end
        e = sb.pop_front();
        for (int i = 0; i < NI; i++) begin
            check_eq("latency", i, 32'(lat[i]), 32'(16 / (1 << i) + 1));
            check_eq("y", i, 32'(y_w[i]), 32'(e.y));
            check_eq("bo", i, 32'(bo_w[i]), 32'(e.bo));
            check_eq("ovf", i, 32'(ovf_w[i]), 32'(e.ovf));
            check_eq("busy_in_ready", i, 32'(in_ready_w[i]), 32'd0);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            a = ~a;
            b = ~b;
            in_valid = 1'b1;
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                check_eq("stall_y", i, 32'(y_w[i]), 32'(e.y));
                check_eq("stall_valid", i, 32'(out_valid_w[i]), 32'd1);
                check_eq("stall_in_ready", i, 32'(in_ready_w[i]), 32'd0);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check_eq("exit_valid", i, 32'(out_valid_w[i]), 32'd0);
            check_eq("exit_in_ready", i, 32'(in_ready_w[i]), 32'd1);
            check_eq("exit_y_kept", i, 32'(y_w[i]), 32'(e.y));
        end
        $display("op a=%h b=%h bin=%0d -> y=%h bo=%0d ovf=%0d", ta, tb_v, tbin,
                 e.y, e.bo, e.ovf);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < NI; i++) begin
            check_eq({tag, "_in_ready"}, i, 32'(in_ready_w[i]), 32'd0);
            check_eq({tag, "_out_valid"}, i, 32'(out_valid_w[i]), 32'd0);
            check_eq({tag, "_y"}, i, 32'(y_w[i]), 32'd0);
            check_eq({tag, "_bo"}, i, 32'(bo_w[i]), 32'd0);
            check_eq({tag, "_ovf"}, i, 32'(ovf_w[i]), 32'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++)
            check_eq("ready_after_reset", i, 32'(in_ready_w[i]), 32'd1);

        // Directed cases
        do_op(16'h1234, 16'h0234, 1'b0, 0);
        do_op(16'h0000, 16'hFFFF, 1'b0, 0);
        do_op(16'h0005, 16'h0005, 1'b1, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 0);
        do_op(16'hA5C3, 16'h1F0E, 1'b1, 5);

        // Reset in mid-CALC: result discarded, outputs cleared at once.
        out_ready = 1'b0;
        launch(16'h4321, 16'h0123, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++)
            check_eq("ready_after_mid_reset", i, 32'(in_ready_w[i]), 32'd1);
        do_op(16'h00FF, 16'h000F, 1'b0, 0);

        // Random operands
        for (int n = 0; n < 1000; n++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
